// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-4 Booth MAC: FSM states, digit
// select codes and the 3-bit Booth recoder.
package booth_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_P1   = 3'd1,
    SEL_P2   = 3'd2,
    SEL_M1   = 3'd3,
    SEL_M2   = 3'd4
  } sel_t;

  // {b[2i+1], b[2i], b[2i-1]} -> partial product multiple of A
  function automatic sel_t booth_recode(input logic [2:0] d);
    case (d)
      3'b001, 3'b010: return SEL_P1;
      3'b011:         return SEL_P2;
      3'b100:         return SEL_M2;
      3'b101, 3'b110: return SEL_M1;
      default:        return SEL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_mac_if.sv
// Operand / result handshake bundle for booth_seq_mac.
interface booth_seq_mac_if #(
  parameter int N     = 16,
  parameter int ACC_W = 40
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [N-1:0]     a;
  logic signed [N-1:0]     b;
  logic                    acc_clr;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] acc;
  logic                    busy;

  modport master (
    output in_valid, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, acc, busy
  );

  modport slave (
    input  in_valid, a, b, acc_clr, out_ready,
    output in_ready, out_valid, acc, busy
  );
endinterface

// File: rtl/booth_pp_sel.sv
// Builds the CLA B-input and carry-in for one Booth digit: 0, +-A, +-2A
// scaled by 4^i; negation is ~term with cin=1 so the adder does the +1.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int N     = 16,
  parameter int ACC_W = 40,
  parameter int SW    = 4
) (
  input  logic signed [N-1:0] a,
  input  logic [2:0]          digit,
  input  logic [SW-1:0]       shamt,
  output logic [ACC_W-1:0]    pp,
  output logic                cin
);
  sel_t             sel;
  logic [ACC_W-1:0] ax, mag, sh;

  always_comb begin
    sel = booth_recode(digit);
    ax  = {{(ACC_W-N){a[N-1]}}, a};
    mag = (sel == SEL_P2 || sel == SEL_M2) ? (ax << 1) : ax;
    sh  = mag << shamt;
    pp  = '0;
    cin = 1'b0;
    case (sel)
      SEL_P1, SEL_P2: pp = sh;
      SEL_M1, SEL_M2: begin
        pp  = ~sh;
        cin = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/cla.sv
// Generic W-bit adder with propagate/generate carry chain.
module cla #(
  parameter int W = 40
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W-1:0] p, g;
  logic [W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign sum  = p ^ c[W-1:0];
  assign cout = c[W];
endmodule

// File: rtl/booth_seq_mac.sv
// Sequential radix-4 Booth multiply-accumulate: one Booth digit per cycle
// through a single shared CLA, result held in acc until the next run ends.
module booth_seq_mac
  import booth_pkg::*;
#(
  parameter int N     = 16,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  booth_seq_mac_if.slave   bus
);
  localparam int CW   = $clog2(N/2);
  localparam int SW   = CW + 1;
  localparam int LAST = N/2 - 1;

  state_t              state, nxt;
  logic signed [N-1:0] a_q;
  logic [N:0]          b_q;      // b with the implicit b[-1]=0 at bit 0
  logic [ACC_W-1:0]    wacc, acc_q, sum, pp;
  logic                cin;
  logic [CW-1:0]       cnt;
  logic [SW-1:0]       shamt;
  logic [2:0]          digit;
  logic                last;

  assign shamt = {cnt, 1'b0};
  assign digit = b_q[shamt +: 3];
  assign last  = (cnt == CW'(LAST));

  booth_pp_sel #(.N(N), .ACC_W(ACC_W), .SW(SW)) u_pp (
    .a     (a_q),
    .digit (digit),
    .shamt (shamt),
    .pp    (pp),
    .cin   (cin)
  );

  // carry-out is meaningless: accumulation wraps modulo 2^ACC_W
  cla #(.W(ACC_W)) u_cla (
    .a    (wacc),
    .b    (pp),
    .cin  (cin),
    .sum  (sum),
    .cout ()
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid) nxt = S_RUN;
      S_RUN:   if (last)         nxt = S_DONE;
      S_DONE:  if (bus.out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == S_IDLE) && !rst;
    bus.busy      = (state == S_RUN);
    bus.out_valid = (state == S_DONE);
    bus.acc       = acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      wacc  <= '0;
      acc_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          a_q  <= bus.a;
          b_q  <= {bus.b, 1'b0};
          wacc <= bus.acc_clr ? '0 : acc_q;
          cnt  <= '0;
        end
        S_RUN: begin
          wacc <= sum;
          cnt  <= cnt + 1'b1;
          if (last) acc_q <= sum;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_seq_mac.sv
// Randomised bench for booth_seq_mac against a timeline/arithmetic model.
module tb_booth_seq_mac;
  localparam int N     = 16;
  localparam int ACC_W = 40;
  localparam int LAT   = N/2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  booth_seq_mac_if #(.N(N), .ACC_W(ACC_W)) bus ();

  booth_seq_mac #(.N(N), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: expected acc, pending result, and where in the op timeline we are
  logic [ACC_W-1:0] m_acc  = '0;
  logic [ACC_W-1:0] m_pend = '0;
  bit               m_busy = 1'b0;
  bit               m_ov   = 1'b0;
  int               cyc    = 0;
  int               m_done_at = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc  = '0;
      m_busy = 1'b0;
      m_ov   = 1'b0;
    end else begin
      cyc++;
      if (m_busy) begin
        if (cyc == m_done_at) begin
          m_busy = 1'b0;
          m_ov   = 1'b1;
          m_acc  = m_pend;
        end
      end else if (m_ov) begin
        if (bus.out_ready) m_ov = 1'b0;
      end else if (bus.in_valid) begin
        m_pend    = ACC_W'((bus.acc_clr ? 64'd0 : {24'd0, m_acc})
                           + longint'(bus.a) * longint'(bus.b));
        m_busy    = 1'b1;
        m_done_at = cyc + LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("acc",       longint'($unsigned(bus.acc)), longint'(m_acc));
      chk("out_valid", longint'(bus.out_valid), longint'(m_ov));
      chk("busy",      longint'(bus.busy), longint'(m_busy));
      chk("in_ready",  longint'(bus.in_ready), longint'(!rst && !m_busy && !m_ov));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_lit(input string name, input longint exp);
    chk({name, "_dut"},   longint'(bus.acc), exp);
    chk({name, "_model"}, longint'($signed(m_acc)), exp);
  endtask

  task automatic do_op(input logic signed [N-1:0] av, input logic signed [N-1:0] bv,
                       input logic clr, input int bp, input bit junk);
    int lat, w;
    w = 0;
    while (!bus.in_ready && w < 50) begin step(); w++; end
    chk("in_ready_wait", longint'(bus.in_ready), 1);
    bus.a = av; bus.b = bv; bus.acc_clr = clr; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      bus.a = N'($urandom); bus.b = N'($urandom); bus.acc_clr = 1'($urandom);
      bus.in_valid = junk && ($urandom_range(0, 2) == 0);
      step();
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("latency", lat, LAT);
    for (int i = 0; i < bp; i++) begin
      bus.in_valid = junk;
      step();
    end
    bus.in_valid = 1'b0;
    if (bp > 0) chk("bp_in_ready", longint'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.acc_clr = 1'b0; bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_acc",  longint'(bus.acc), 0);
    chk("rst_ov",   longint'(bus.out_valid), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk_on = 1'b1;

    do_op(16'sd3, 16'sd5, 1'b1, 0, 1'b0);      chk_lit("basic", 15);
    do_op(-16'sd7, 16'sd6, 1'b0, 0, 1'b0);     chk_lit("accum", -27);
    do_op(16'sd10, -16'sd20, 1'b1, 0, 1'b0);   chk_lit("clr", -200);
    do_op(-16'sd32768, -16'sd32768, 1'b1, 0, 1'b0); chk_lit("minmin", 1073741824);
    do_op(16'sd32767, -16'sd32768, 1'b1, 0, 1'b0);  chk_lit("maxmin", -1073709056);
    do_op(-16'sd1, -16'sd1, 1'b1, 0, 1'b0);    chk_lit("m1m1", 1);

    // backpressure with in_valid pulsed throughout RUN/DONE
    do_op(16'sd123, -16'sd45, 1'b0, 5, 1'b1);  chk_lit("bp", 1 - 5535);

    // abort in RUN cycle 4
    bus.a = 16'sd100; bus.b = 16'sd100; bus.acc_clr = 1'b1; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    chk("abort_acc",  longint'(bus.acc), 0);
    chk("abort_ov",   longint'(bus.out_valid), 0);
    chk("abort_busy", longint'(bus.busy), 0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_ov", longint'(seen), 0);
    chk_lit("abort_zero", 0);

    for (int t = 0; t < 1000; t++)
      do_op(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
            ($urandom_range(0, 3) == 0));

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/booth_seq_mac.md
Name: booth_seq_mac

Overview:
- Sequential radix-4 Booth multiply-accumulate controller that time-shares one existing `cla` adder instance.
- Each accepted operand pair (a, b) is retired one Booth digit per cycle: the selected partial product (0, ±A, ±2A) is added into the accumulator through the CLA.
- Sits in the MACC path between the CNN operand feeder and the result writer.
- Operands are accepted on a valid/ready handshake; results are returned on a valid/ready handshake.

Parameters:
- N, 16, signed operand width; must be even and ≥4.
- ACC_W, 40, accumulator width and CLA width; must be ≥ 2N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  N  signed multiplicand.
- b  input  N  signed multiplier (Booth-recoded).
- acc_clr  input  1  sampled with the operand pair; 1 = start from 0, 0 = add to the held accumulator.
- out_valid  output  1  acc holds a completed result.
- out_ready  input  1  downstream consumes the result.
- acc  output  ACC_W  signed accumulator value.
- busy  output  1  high in RUN.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, acc=0, out_valid=0, busy=0, digit counter=0.
  - in_ready=1 once rst deasserts.
  - Reset mid-RUN or mid-DONE aborts the operation, clears acc and emits no out_valid.
- State machine IDLE → RUN → DONE → IDLE:
  - IDLE:
    - in_ready=1.
    - On in_valid at an edge: latch a and b.
    - Working accumulator ← 0 if acc_clr, else ← acc.
    - cnt ← 0; go to RUN.
  - RUN:
    - in_ready=0, busy=1.
    - Each edge adds partial product for digit cnt, then cnt++.
    - On the edge where cnt == N/2−1, the final sum is written to acc and the state goes to DONE.
  - DONE:
    - out_valid=1; acc is stable.
    - On out_ready: out_valid falls and the state goes to IDLE.
    - in_ready stays 0 in DONE, so a new pair is accepted at the earliest one cycle after out_ready.
- Latency:
  - Acceptance at edge k gives out_valid high after edge k+N/2 (8 cycles for N=16), fixed.
  - Zero digits still consume a cycle.
- Booth digit i (0..N/2−1):
  - Recode bits {b[2i+1], b[2i], b[2i−1]}, with b[−1]=0.
  - 000, 111 → 0.
  - 001, 010 → +A.
  - 011 → +2A.
  - 100 → −2A.
  - 101, 110 → −A.
- Partial product formation:
  - A is sign-extended to ACC_W; 2A is A<<1.
  - The magnitude term is shifted left by 2i, bits above ACC_W discarded.
  - Negative digit: CLA B-input = bitwise NOT of the shifted term, Cin=1.
  - Positive or zero digit: Cin=0.
  - Zero digit: B-input = 0, Cin=0.
- CLA connections:
  - A-input = working accumulator.
  - CLA Cout is ignored.
  - Arithmetic wraps modulo 2^ACC_W; there is no saturation and no overflow flag.
- Input handling:
  - Inputs are ignored outside IDLE.
  - Operand changes after acceptance have no effect because a and b are latched.
- Outputs:
  - acc updates only at RUN completion or reset; it holds across IDLE.
  - With acc_clr=0, the next operation accumulates onto the held acc.

Decomposition:
- Shared package booth_pkg:
  - State encodings S_IDLE/S_RUN/S_DONE.
  - Booth select codes SEL_ZERO/SEL_P1/SEL_P2/SEL_M1/SEL_M2.
  - Recode function from 3 bits to select code.
- Sub-module booth_pp_sel (combinational):
  - Inputs: latched A, 3-bit digit, shift amount.
  - Outputs: ACC_W-bit CLA B-input and Cin.
- The existing cla #(ACC_W) is instantiated unchanged as the adder.

Test Plan (N=16, ACC_W=40):
- Reset: assert rst mid-cycle → acc=0, out_valid=0, busy=0 immediately; in_ready=1 after release.
- Basic product: a=3, b=5, acc_clr=1 → busy for 8 cycles; out_valid after the 8th edge; acc=15.
- Accumulate: then a=−7, b=6, acc_clr=0 → acc=−27; then a=10, b=−20, acc_clr=1 → acc=−200.
- Extremes:
  - a=−32768, b=−32768, clr=1 → acc=1073741824.
  - a=32767, b=−32768, clr=1 → acc=−1073709056.
  - a=−1, b=−1 → acc=1.
- Backpressure and abort:
  - Hold out_ready=0 for 5 cycles in DONE → acc stable, in_ready=0; in_valid pulsed during RUN/DONE is not accepted.
  - Assert rst at RUN cycle 4 → IDLE, acc=0, no out_valid.
- Random: 1000 random signed pairs with random acc_clr → acc matches a reference model of the sum of a*b modulo 2^40; latency always exactly 8 cycles.
